// File: rtl/traffic_pkg.sv
// Shared phase encoding, light layout and grant helper for the traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {
    PhAllRed = 2'd0,
    PhGreen  = 2'd1,
    PhYellow = 2'd2
  } phase_e;

  localparam int unsigned LightRedBit  = 0;
  localparam int unsigned LightYelBit  = 1;
  localparam int unsigned LightGrnBit  = 2;
  localparam int unsigned LightWalkBit = 3;

  localparam logic [3:0] LightRed = 4'b0001 << LightRedBit;
  localparam logic [3:0] LightYel = 4'b0001 << LightYelBit;
  localparam logic [3:0] LightGrn = (4'b0001 << LightGrnBit) | (4'b0001 << LightWalkBit);

  function automatic logic [3:0] light_for(phase_e ph, logic sel);
    logic [3:0] l;
    l = LightRed;
    if (sel) begin
      case (ph)
        PhGreen:  l = LightGrn;
        PhYellow: l = LightYel;
        default:  l = LightRed;
      endcase
    end
    return l;
  endfunction

  // Round-robin search starting after 'last'; returns {found, dir}.
  function automatic logic [2:0] rr_pick(logic [3:0] req, logic [1:0] last);
    logic [2:0] res;
    logic [1:0] d;
    res = 3'b000;
    for (int unsigned k = 4; k >= 1; k--) begin
      d = last + 2'(k);
      if (req[d]) res = {1'b1, d};
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a single-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 125000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach signal controller: round-robin green grants with emergency preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 125000000,
  parameter int unsigned GREEN_MIN = 5,
  parameter int unsigned GREEN_MAX = 7,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic       emg_ack,
  output logic [3:0] light_1,
  output logic [3:0] light_2,
  output logic [3:0] light_3,
  output logic [3:0] light_4,
  output logic [1:0] phase,
  output logic [1:0] cur_dir
);

  localparam int unsigned MaxGy  = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int unsigned MaxLen = (MaxGy > ALLRED_T) ? MaxGy : ALLRED_T;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
  localparam logic [CntW-1:0] GreenMinLs = CntW'(GREEN_MIN - 1);
  localparam logic [CntW-1:0] GreenMaxLs = CntW'(GREEN_MAX - 1);
  localparam logic [CntW-1:0] YellowLs   = CntW'(YELLOW_T - 1);
  localparam logic [CntW-1:0] AllRedLs   = CntW'(ALLRED_T - 1);

  logic tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  phase_e          phase_q, phase_d;
  logic [1:0]      dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0][3:0] lights_q, lights_d;

  logic [CntW-1:0] cnt_inc;
  logic            others;
  logic [2:0]      pick;

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    // Saturate so a held emergency green cannot wrap back below the limits.
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    others  = |(req & ~(4'b0001 << dir_q));
    pick    = rr_pick(req, dir_q);

    if (tick) begin
      cnt_d = cnt_inc;
      unique case (phase_q)
        PhAllRed: begin
          if (cnt_q >= AllRedLs) begin
            if (emg_valid) begin
              phase_d = PhGreen;
              dir_d   = emg_dir;
              cnt_d   = '0;
            end else if (pick[2]) begin
              phase_d = PhGreen;
              dir_d   = pick[1:0];
              cnt_d   = '0;
            end
          end
        end
        PhGreen: begin
          if (emg_valid) begin
            if (emg_dir != dir_q) begin
              phase_d = PhYellow;
              cnt_d   = '0;
            end
          end else if ((cnt_q >= GreenMinLs && (others || !req[dir_q])) ||
                       cnt_q >= GreenMaxLs) begin
            phase_d = PhYellow;
            cnt_d   = '0;
          end
        end
        PhYellow: begin
          if (cnt_q >= YellowLs) begin
            phase_d = PhAllRed;
            cnt_d   = '0;
          end
        end
        default: begin
          phase_d = PhAllRed;
          cnt_d   = '0;
        end
      endcase
    end

    for (int n = 0; n < 4; n++) begin
      lights_d[n] = light_for(phase_d, dir_d == 2'(n));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PhAllRed;
      dir_q    <= 2'd3;
      cnt_q    <= '0;
      lights_q <= {4{LightRed}};
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
    end
  end

  assign light_1 = lights_q[0];
  assign light_2 = lights_q[1];
  assign light_3 = lights_q[2];
  assign light_4 = lights_q[3];
  assign phase   = phase_q;
  assign cur_dir = dir_q;
  assign emg_ack = emg_valid && (phase_q == PhGreen) && (emg_dir == dir_q);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized and directed bench for traffic_phase_scheduler against a tick-level reference model.
module tb_traffic_phase_scheduler;

  localparam int TickDiv = 4;
  localparam int GMin    = 5;
  localparam int GMax    = 7;
  localparam int YelT    = 2;
  localparam int ArT     = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       emg_valid;
  logic [1:0] emg_dir;
  logic       emg_ack;
  logic [3:0] light_1, light_2, light_3, light_4;
  logic [1:0] phase;
  logic [1:0] cur_dir;

  traffic_phase_scheduler #(
    .TICK_DIV (TickDiv),
    .GREEN_MIN(GMin),
    .GREEN_MAX(GMax),
    .YELLOW_T (YelT),
    .ALLRED_T (ArT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .emg_valid(emg_valid),
    .emg_dir  (emg_dir),
    .emg_ack  (emg_ack),
    .light_1  (light_1),
    .light_2  (light_2),
    .light_3  (light_3),
    .light_4  (light_4),
    .phase    (phase),
    .cur_dir  (cur_dir)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0/1/2, granted approach, ticks completed in the current phase,
  // and clock edges seen since reset was released.
  int m_phase, m_dir, m_el, m_edge;

  task automatic model_reset();
    m_phase = 0;
    m_dir   = 3;
    m_el    = 0;
    m_edge  = 0;
  endtask

  function automatic int model_grant();
    int g;
    if (emg_valid) return int'(emg_dir);
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      if (g < 0 && req[(m_dir + k) % 4]) g = (m_dir + k) % 4;
    end
    return g;
  endfunction

  task automatic model_edge();
    int done, g;
    bit others;
    if (rst) begin
      model_reset();
      return;
    end
    m_edge++;
    if (m_edge % TickDiv != 0) return;
    done = m_el + 1;
    others = 1'b0;
    for (int n = 0; n < 4; n++) if (n != m_dir && req[n]) others = 1'b1;
    case (m_phase)
      0: begin
        g = (done >= ArT) ? model_grant() : -1;
        if (g >= 0) begin m_phase = 1; m_dir = g; m_el = 0; end
        else m_el = done;
      end
      1: begin
        if (emg_valid && int'(emg_dir) != m_dir) begin m_phase = 2; m_el = 0; end
        else if (emg_valid) m_el = done;
        else if ((done >= GMin && (others || !req[m_dir])) || done >= GMax) begin
          m_phase = 2; m_el = 0;
        end else m_el = done;
      end
      default: begin
        if (done >= YelT) begin m_phase = 0; m_el = 0; end
        else m_el = done;
      end
    endcase
  endtask

  function automatic logic [3:0] model_light(int n);
    if (n == m_dir && m_phase == 1) return 4'b1100;
    if (n == m_dir && m_phase == 2) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic compare_all();
    logic [3:0] lts [4];
    int live;
    lts[0] = light_1; lts[1] = light_2; lts[2] = light_3; lts[3] = light_4;
    check("phase", phase, m_phase);
    check("cur_dir", cur_dir, m_dir);
    live = 0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("light_%0d", n + 1), lts[n], model_light(n));
      if (lts[n][2] || lts[n][1]) live++;
    end
    check("emg_ack", emg_ack, emg_valid && m_phase == 1 && int'(emg_dir) == m_dir);
    check("one_live", live <= 1, 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int limit, input string tag);
    int k = 0;
    while (phase !== 2'(ph) && k < limit) begin
      cycle();
      k++;
    end
    check(tag, phase, ph);
  endtask

  task automatic measure_green(output int len);
    len = 0;
    while (phase == 2'd1 && len < 400) begin
      cycle();
      len++;
    end
  endtask

  int grants[$];
  int glens[$];
  int run, k, len;
  logic [1:0] prev;

  initial begin
    n_tests = 0;
    n_fail = 0;
    req = 4'b0000;
    emg_valid = 1'b0;
    emg_dir = 2'd0;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_lights", {light_1, light_2, light_3, light_4}, 16'h1111);
    check("rst_phase", phase, 0);
    check("rst_dir", cur_dir, 3);
    cycle();
    rst = 1'b0;

    // Idle: nothing requested.
    repeat (40) cycle();
    check("idle_phase", phase, 0);

    // Alternating requests on 0 and 2.
    req = 4'b0101;
    prev = phase;
    run = 0;
    repeat (140) begin
      cycle();
      if (phase == 2'd1 && prev != 2'd1) grants.push_back(int'(cur_dir));
      if (phase == 2'd1) run++;
      else if (prev == 2'd1) begin glens.push_back(run); run = 0; end
      prev = phase;
    end
    check("rr_count", grants.size() >= 4, 1);
    check("rr_glens", glens.size() >= 3, 1);
    if (grants.size() >= 4) begin
      check("rr_g0", grants[0], 0);
      check("rr_g1", grants[1], 2);
      check("rr_g2", grants[2], 0);
      check("rr_g3", grants[3], 2);
    end
    if (glens.size() >= 3) begin
      check("rr_len0", glens[0], 20);
      check("rr_len1", glens[1], 20);
    end

    // Single requester extends to GREEN_MAX; dropping the request ends at GREEN_MIN.
    req = 4'b0010;
    do_reset();
    wait_phase(1, 20, "solo_green");
    check("solo_dir", cur_dir, 1);
    measure_green(len);
    check("solo_len", len, 28);
    do_reset();
    wait_phase(1, 20, "drop_green");
    req = 4'b0000;
    measure_green(len);
    check("drop_len", len, 20);

    // Emergency preemption toward approach 3 while 0 is green.
    req = 4'b0001;
    do_reset();
    wait_phase(1, 20, "emg_pre_green");
    check("emg_pre_dir", cur_dir, 0);
    emg_valid = 1'b1;
    emg_dir = 2'd3;
    k = 0;
    while (phase !== 2'd2 && k < 20) begin cycle(); k++; end
    check("emg_to_yellow", k, 4);
    wait_phase(1, 40, "emg_green");
    check("emg_dir_granted", cur_dir, 3);
    check("emg_ack_on", emg_ack, 1);
    repeat (80) cycle();
    check("emg_hold_phase", phase, 1);
    check("emg_hold_dir", cur_dir, 3);
    emg_valid = 1'b0;
    repeat (20) cycle();

    // Reset pulse in the middle of yellow.
    req = 4'b0011;
    do_reset();
    wait_phase(2, 60, "pre_rst_yellow");
    cycle();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_l1", light_1, 4'b0001);
    compare_all();
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    check("rst_no_tick", phase, 0);

    // Randomized traffic with emergency episodes.
    do_reset();
    repeat (3000) begin
      if ($urandom_range(15) == 0) req = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) emg_valid = ~emg_valid;
      if ($urandom_range(19) == 0) emg_dir = 2'($urandom_range(3));
      if ($urandom_range(999) == 0) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 125000000, clk cycles per timing tick (1 s at 125 MHz); legal range 2 and above.
REQ-002 Parameter GREEN_MIN, default 5, minimum green length in ticks.
REQ-003 Parameter GREEN_MAX, default 7, maximum green length in ticks; GREEN_MAX >= GREEN_MIN >= 1.
REQ-004 Parameter YELLOW_T, default 2, yellow length in ticks.
REQ-005 Parameter ALLRED_T, default 1, all-red clearance length in ticks.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  reset: asynchronous, active-high.
REQ-008 req  input  4  vehicle-presence level per approach; bit n = approach n.
REQ-009 emg_valid  input  1  emergency preemption request, level.
REQ-010 emg_dir  input  2  approach requested by the emergency vehicle; sampled while emg_valid=1.
REQ-011 emg_ack  output  1  high while emg_valid=1 and approach emg_dir is green.
REQ-012 light_1..light_4  output  4 each  {walk, green, yellow, red}, one-hot in bits [2:0]; walk = green.
REQ-013 phase  output  2  0=ALL_RED, 1=GREEN, 2=YELLOW.
REQ-014 cur_dir  output  2  approach currently or most recently granted.

Function
REQ-015 Internal tick: single-cycle pulse every TICK_DIV clk cycles; first tick TICK_DIV cycles after rst deasserts.
REQ-016 State and tick-counter updates occur only on tick cycles; outputs are registered and change on the clk edge of a tick cycle.
REQ-017 Tick counter clears on every state entry; state duration is exactly N ticks (exit on tick where count == N-1).
REQ-018 ALL_RED: all lights red; after ALLRED_T ticks, grant selection runs on each tick until a grant is made.
REQ-019 Grant priority: emg_valid=1 -> emg_dir; otherwise round-robin, first approach with req=1 searching cur_dir+1, +2, +3, cur_dir (mod 4).
REQ-020 No requests and no emergency: remain in ALL_RED, re-evaluating on every tick.
REQ-021 GREEN: only light_(cur_dir+1) green+walk, others red.
REQ-022 GREEN exits to YELLOW at GREEN_MIN ticks if any other approach has req=1; otherwise extends while req[cur_dir]=1, forced exit at GREEN_MAX.
REQ-023 GREEN with req[cur_dir]=0 and no other request exits at GREEN_MIN.
REQ-024 Emergency, emg_dir == cur_dir in GREEN: green held indefinitely while emg_valid=1, GREEN_MAX ignored; on drop, normal REQ-022 rules resume against the running count.
REQ-025 Emergency, emg_dir != cur_dir in GREEN: exit to YELLOW on the next tick regardless of GREEN_MIN.
REQ-026 YELLOW: only cur_dir yellow, others red; after YELLOW_T ticks -> ALL_RED; never truncated.
REQ-027 emg_dir changing mid-preemption: the latest value applies at the next grant decision.
REQ-028 Count width sized for max(GREEN_MAX, YELLOW_T, ALLRED_T); no wrap possible during held emergency green (count saturates).
REQ-029 Never more than one approach in non-red simultaneously, including the clk edge of any transition.

Reset
REQ-030 rst=1: phase=ALL_RED, cur_dir=3 (first round-robin search starts at 0), all lights 4'b0001, emg_ack=0, tick divider and counter cleared.
REQ-031 Reset mid-green or mid-yellow forces all-red immediately (asynchronous); no yellow is inserted.

Structure
REQ-032 Phase encoding, light bit positions, and light constants (RED=4'b0001, YEL=4'b0010, GRN=4'b1100) are in shared package traffic_pkg.
REQ-033 Tick generation is sub-module tick_prescaler (clk, rst, tick), parameter TICK_DIV.

Verification (TICK_DIV=4, defaults otherwise)
REQ-034 Reset, req=4'b0000 for 40 cycles -> phase stays 0, all lights 4'b0001, emg_ack=0.
REQ-035 req=4'b0101 constant -> grants 0,2,0,2; each green 5 ticks (20 cycles), yellow 8 cycles, all-red 4 cycles.
REQ-036 req=4'b0010 only -> approach 1 green 7 ticks (28 cycles), then yellow; with req=4'b0000 after the grant -> green 5 ticks.
REQ-037 Approach 0 green at tick 1, emg_valid=1 with emg_dir=3 -> yellow on the next tick, 2 ticks yellow, 1 tick all-red, approach 3 green, emg_ack=1; hold 20 ticks -> still green.
REQ-038 rst pulse of 1 cycle mid-yellow -> lights 4'b0001 in the same cycle, no tick for 4 cycles afterwards.
REQ-039 Continuous assertion across all tests: at most one light_n bit[2] or bit[1] set at any time.
